sevenseg_capture: RTL
=====================

# sevenseg_capture

Receive-side counterpart of the team's BCD-to-seven-segment encoder. It watches a multiplexed 4-digit, active-low seven-segment display bus (segment lines plus per-digit anode enables), decodes each stable digit pattern back to a BCD nibble, and assembles complete 4-digit frames. Each completed frame is reported with a one-cycle valid strobe. It is used as an on-chip display monitor and as a loopback checker for the display driver path.

## Interface
Parameters:
- STABLE_CYCLES, default 4: consecutive cycles a synchronized {an_n, seg_n} sample must hold before it is captured. Legal range 1..255.

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- seg_n  in  7  segment lines, active-low; bit0 = a … bit6 = g
- an_n  in  4  digit enables, active-low; an_n[i] low selects digit slot i (slot 3 = most significant)
- digits  out  16  last complete frame; slot i in digits[4i+3:4i]
- blank  out  4  per-slot: the slot showed all segments off
- bad  out  4  per-slot: the slot showed an undecodable pattern
- frame_valid  out  1  one-cycle pulse when digits/blank/bad update
- frame_err  out  1  OR of bad for the last frame; held with the frame

## Operation
- Inputs pass through a 2-flop synchronizer. The resulting sample S = {an_n, seg_n} is 11 bits.
- Decode table for the seg_n pattern, listed as bit6..bit0:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - 1111111 decodes to nibble F with blank=1.
  - Any other pattern decodes to nibble E with bad=1.
- S is "valid-select" when exactly one an_n bit is low. 0000 or multiple lows, e.g. 1100, are not valid-select. 1111 is idle.
- The settle FSM uses an 8-bit counter cnt and a previous-sample register P:
  - WAIT: entered from reset, with P = 11'h7FF. If S≠P and S is valid-select: go to SETTLE with cnt=1. Otherwise stay.
  - SETTLE:
    - If S≠P: if S is valid-select, cnt=1 and stay in SETTLE; otherwise go to WAIT.
    - If S=P: cnt++. When cnt reaches STABLE_CYCLES, capture the slot and go to HELD.
  - HELD: stay until S≠P, then follow the same rule as WAIT.
  - P is updated to S every cycle.
  - With STABLE_CYCLES=1, the capture occurs in the first cycle a new valid-select sample appears.
- Capture writes the decoded nibble, blank bit and bad bit into shadow slot i and sets mask[i]. Recapturing a slot before the frame completes overwrites it (latest wins).
- Frame completion: when a capture makes mask=4'hF:
  - The shadow contents, including the capture being made, are copied to digits/blank/bad.
  - frame_err is set to the OR of the new bad bits.
  - frame_valid is pulsed.
  - mask is cleared.
  - Shadow slots are not cleared.
- Outputs hold between frames. Slot order within a frame is irrelevant.

## Timing
- Reset values:
  - digits=16'h0000, blank=4'hF, bad=4'h0, frame_valid=0, frame_err=0.
  - FSM in WAIT, mask=0, P=11'h7FF, shadow slots cleared.
- Reset takes effect asynchronously and may be asserted mid-frame. A partially collected frame is discarded; the next frame needs four fresh captures.
- Latency: pins stable from edge t. S is stable from t+2. The capture register updates at edge t+2+STABLE_CYCLES.
- frame_valid is high for exactly the one cycle following the completing capture edge. It is never asserted on consecutive cycles, because each capture requires at least one settle period.
- A sample held less than STABLE_CYCLES cycles is never captured. Returning to the same pattern after a change restarts the count.
- A single long activation yields one capture (HELD blocks repeats).

## Test plan
- STABLE_CYCLES=4; drive "1234" by holding each of the following for 8 cycles, separated by 2 idle cycles (an_n=1111):
  - slot3 = 1111001, slot2 = 0100100, slot1 = 0110000, slot0 = 0011001.
  - Required response: exactly one frame_valid pulse, digits=16'h1234, blank=0, bad=0, frame_err=0.
- Glitch filter: slot2 shows pattern "5" for 3 cycles only, then "7" for 6 cycles, and the other slots are driven normally -> digits[11:8]=7, with no capture of 5.
- Blank/invalid: slot3=1111111, slot0=0000001, slots 1 and 2 show "0" -> digits=16'hF00E, blank=4'b1000, bad=4'b0001, frame_err=1.
- Illegal select: an_n=1100 held for 10 cycles, then an_n=0000 held for 10 cycles -> no capture, mask unchanged, no frame_valid.
- Reset mid-frame: capture slots 3 and 2, assert rst_n low for 1 cycle -> outputs return to reset values immediately. Then drive slots 1 and 0 only -> no frame_valid until slots 3 and 2 are recaptured.
- Sweep STABLE_CYCLES=1 and 255 through the "1234" scenario -> captures occur exactly at t+3 and t+257.

Source files
------------

// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - multiplexed 4-digit active-low seven-segment bus monitor
// Filters each digit slot for stability, decodes it back to BCD and assembles 4-digit frames.
module sevenseg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  bad,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam logic [7:0] STABLE_C = STABLE_CYCLES[7:0];

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HELD} state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [10:0] sync1_q, sync2_q, prev_q;
  logic [15:0] sh_dig_q, sh_dig_d;
  logic [3:0]  sh_blank_q, sh_blank_d;
  logic [3:0]  sh_bad_q, sh_bad_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] digits_q;
  logic [3:0]  blank_q, bad_q;
  logic        frame_valid_q, frame_err_q;

  logic [3:0]  s_an;
  logic [6:0]  s_seg;
  logic        changed_w, valid_sel_w, restart_w, capture_w, frame_done_w;
  logic [1:0]  slot_w;
  logic [3:0]  nib_w;
  logic        is_blank_w, is_bad_w;

  assign s_an      = sync2_q[10:7];
  assign s_seg     = sync2_q[6:0];
  assign changed_w = (sync2_q != prev_q);
  assign restart_w = changed_w && valid_sel_w;

  always_comb begin
    valid_sel_w = 1'b1;
    slot_w      = 2'd0;
    unique case (s_an)
      4'b1110: slot_w = 2'd0;
      4'b1101: slot_w = 2'd1;
      4'b1011: slot_w = 2'd2;
      4'b0111: slot_w = 2'd3;
      default: valid_sel_w = 1'b0;
    endcase
  end

  // Reverse of the encoder table; anything unrecognised is flagged rather than guessed.
  always_comb begin
    nib_w      = 4'hE;
    is_blank_w = 1'b0;
    is_bad_w   = 1'b0;
    unique case (s_seg)
      7'b1000000: nib_w = 4'd0;
      7'b1111001: nib_w = 4'd1;
      7'b0100100: nib_w = 4'd2;
      7'b0110000: nib_w = 4'd3;
      7'b0011001: nib_w = 4'd4;
      7'b0010010: nib_w = 4'd5;
      7'b0000010: nib_w = 4'd6;
      7'b1111000: nib_w = 4'd7;
      7'b0000000: nib_w = 4'd8;
      7'b0010000: nib_w = 4'd9;
      7'b1111111: begin
        nib_w      = 4'hF;
        is_blank_w = 1'b1;
      end
      default: is_bad_w = 1'b1;
    endcase
  end

  always_comb begin
    capture_w = 1'b0;
    case (state_q)
      ST_SETTLE: capture_w = changed_w ? (restart_w && (STABLE_C == 8'd1))
                                       : ((cnt_q + 8'd1) == STABLE_C);
      default:   capture_w = restart_w && (STABLE_C == 8'd1);
    endcase
  end

  always_comb begin
    sh_dig_d   = sh_dig_q;
    sh_blank_d = sh_blank_q;
    sh_bad_d   = sh_bad_q;
    mask_d     = mask_q;
    if (capture_w) begin
      sh_dig_d[{slot_w, 2'b00} +: 4] = nib_w;
      sh_blank_d[slot_w]             = is_blank_w;
      sh_bad_d[slot_w]               = is_bad_w;
      mask_d[slot_w]                 = 1'b1;
    end
    frame_done_w = capture_w && (mask_d == 4'hF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT;
      cnt_q         <= 8'd0;
      sync1_q       <= 11'h7FF;
      sync2_q       <= 11'h7FF;
      prev_q        <= 11'h7FF;
      sh_dig_q      <= 16'h0000;
      sh_blank_q    <= 4'h0;
      sh_bad_q      <= 4'h0;
      mask_q        <= 4'h0;
      digits_q      <= 16'h0000;
      blank_q       <= 4'hF;
      bad_q         <= 4'h0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      sync1_q <= {an_n, seg_n};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;

      case (state_q)
        ST_SETTLE: begin
          if (changed_w) begin
            if (valid_sel_w) begin
              cnt_q   <= 8'd1;
              state_q <= capture_w ? ST_HELD : ST_SETTLE;
            end else begin
              state_q <= ST_WAIT;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (capture_w) state_q <= ST_HELD;
          end
        end
        ST_WAIT, ST_HELD: begin
          if (restart_w) begin
            cnt_q   <= 8'd1;
            state_q <= capture_w ? ST_HELD : ST_SETTLE;
          end
        end
        default: state_q <= ST_WAIT;
      endcase

      sh_dig_q      <= sh_dig_d;
      sh_blank_q    <= sh_blank_d;
      sh_bad_q      <= sh_bad_d;
      mask_q        <= frame_done_w ? 4'h0 : mask_d;
      frame_valid_q <= frame_done_w;
      if (frame_done_w) begin
        digits_q    <= sh_dig_d;
        blank_q     <= sh_blank_d;
        bad_q       <= sh_bad_d;
        frame_err_q <= |sh_bad_d;
      end
    end
  end

  assign digits      = digits_q;
  assign blank       = blank_q;
  assign bad         = bad_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule
